// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: stage-bundle typedefs and skid-entry state encoding for pipe_stage_reg.
// Revision 1.0 - initial release
`default_nettype none

package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_CSR = 2'd3
  } wb_src_e;

  typedef enum logic [2:0] {
    MEM_NONE = 3'd0,
    MEM_LB   = 3'd1,
    MEM_LH   = 3'd2,
    MEM_LW   = 3'd3,
    MEM_SB   = 3'd4,
    MEM_SH   = 3'd5,
    MEM_SW   = 3'd6
  } mem_op_e;

  typedef enum logic [1:0] {
    CSR_NONE = 2'd0,
    CSR_RW   = 2'd1,
    CSR_RS   = 2'd2,
    CSR_RC   = 2'd3
  } csr_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    wb_src_e     wb_src;
    mem_op_e     mem_op;
    csr_op_e     csr_op;
    logic [11:0] csr_addr;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] store_val;
    logic [4:0]  rd;
    wb_src_e     wb_src;
    logic [31:0] pc;
    mem_op_e     mem_op;
    csr_op_e     csr_op;
    logic [11:0] csr_addr;
  } ex_m1_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    wb_src_e     wb_src;
    logic [31:0] pc;
    mem_op_e     mem_op;
    csr_op_e     csr_op;
    logic [11:0] csr_addr;
  } m1_m2_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        we;
  } m2_wb_t;

  // Entry state is {main_v, skid_v}; the low bit alone drives in_ready.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_FULL  = 2'b10;
  localparam logic [1:0] ST_SKID  = 2'b11;

  function automatic logic is_load(input mem_op_e op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW);
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised valid/ready pipeline register with optional skid entry and stall counter.
// Revision 1.0 - initial release
`default_nettype none

module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SKID_EN     = 1,
  parameter int unsigned CLR_ON_FLSH = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              cnt_clr
);

  logic w_in_fire;
  logic w_out_fire;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  generate
    if (SKID_EN != 0) begin : g_skid
      logic [1:0]        state_q, state_d;
      logic [DATA_W-1:0] main_q, main_d;
      logic [DATA_W-1:0] skid_q, skid_d;

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
          // Any in_fire this cycle is dropped; out_fire has already been seen downstream.
          state_d = ST_EMPTY;
          if (CLR_ON_FLSH != 0) begin
            main_d = '0;
            skid_d = '0;
          end
        end else begin
          case (state_q)
            ST_EMPTY: begin
              if (w_in_fire) begin
                main_d  = in_data;
                state_d = ST_FULL;
              end
            end
            ST_FULL: begin
              if (w_out_fire) begin
                if (w_in_fire) begin
                  main_d = in_data;
                end else begin
                  state_d = ST_EMPTY;
                end
              end else if (w_in_fire) begin
                skid_d  = in_data;
                state_d = ST_SKID;
              end
            end
            ST_SKID: begin
              if (w_out_fire) begin
                main_d  = skid_q;
                state_d = ST_FULL;
              end
            end
            default: state_d = ST_EMPTY;
          endcase
        end
      end

      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          state_q <= ST_EMPTY;
          main_q  <= '0;
          skid_q  <= '0;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
        end
      end

      assign in_ready  = ~state_q[0];
      assign out_valid = state_q[1];
      assign out_data  = main_q;
    end else begin : g_single
      logic              main_v_q, main_v_d;
      logic [DATA_W-1:0] main_q, main_d;

      always_comb begin
        main_v_d = main_v_q;
        main_d   = main_q;
        if (flush) begin
          main_v_d = 1'b0;
          if (CLR_ON_FLSH != 0) begin
            main_d = '0;
          end
        end else if (w_in_fire) begin
          main_v_d = 1'b1;
          main_d   = in_data;
        end else if (w_out_fire) begin
          main_v_d = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          main_v_q <= 1'b0;
          main_q   <= '0;
        end else begin
          main_v_q <= main_v_d;
          main_q   <= main_d;
        end
      end

      assign in_ready  = ~main_v_q | out_ready;
      assign out_valid = main_v_q;
      assign out_data  = main_q;
    end
  endgenerate

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (cnt_clr) begin
      stall_d = '0;
    end else if (out_valid && !out_ready && (stall_q != c_cnt_max)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: vector table, directed corner sequences and random queue-model check of pipe_stage_reg.
// Revision 1.0 - initial release
`default_nettype none

module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic nrst;

  // A: skid entry, payload cleared on flush
  logic       a_fl, a_iv, a_ir, a_ov, a_ordy, a_clr;
  logic [7:0] a_d, a_od;
  logic [15:0] a_st;
  // B: single entry, payload kept on flush
  logic       b_fl, b_iv, b_ir, b_ov, b_ordy, b_clr;
  logic [7:0] b_d, b_od;
  logic [15:0] b_st;
  // C: skid entry, 3-bit stall counter
  logic       c_fl, c_iv, c_ir, c_ov, c_ordy, c_clr;
  logic [7:0] c_d, c_od;
  logic [2:0] c_st;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(8), .SKID_EN(1), .CLR_ON_FLSH(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .nrst(nrst), .flush(a_fl), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_d),
    .out_valid(a_ov), .out_ready(a_ordy), .out_data(a_od), .stall_cnt(a_st), .cnt_clr(a_clr));

  pipe_stage_reg #(.DATA_W(8), .SKID_EN(0), .CLR_ON_FLSH(0), .CNT_W(16)) u_dut_b (
    .clk(clk), .nrst(nrst), .flush(b_fl), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_d),
    .out_valid(b_ov), .out_ready(b_ordy), .out_data(b_od), .stall_cnt(b_st), .cnt_clr(b_clr));

  pipe_stage_reg #(.DATA_W(8), .SKID_EN(1), .CLR_ON_FLSH(1), .CNT_W(3)) u_dut_c (
    .clk(clk), .nrst(nrst), .flush(c_fl), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_d),
    .out_valid(c_ov), .out_ready(c_ordy), .out_data(c_od), .stall_cnt(c_st), .cnt_clr(c_clr));

  typedef struct {
    logic        iv;
    logic [7:0]  d;
    logic        ordy, fl, clr;
    logic        ir, ov, ck;
    logic [7:0]  od;
    logic [15:0] st;
  } vec_t;

  function automatic vec_t mk(int iv, int d, int ordy, int fl, int clr,
                              int ir, int ov, int ck, int od, int st);
    vec_t v;
    v.iv = iv[0]; v.d = d[7:0]; v.ordy = ordy[0]; v.fl = fl[0]; v.clr = clr[0];
    v.ir = ir[0]; v.ov = ov[0]; v.ck = ck[0]; v.od = od[7:0]; v.st = st[15:0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle_all();
    a_fl = 0; a_iv = 0; a_d = 0; a_ordy = 0; a_clr = 0;
    b_fl = 0; b_iv = 0; b_d = 0; b_ordy = 0; b_clr = 0;
    c_fl = 0; c_iv = 0; c_d = 0; c_ordy = 0; c_clr = 0;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #2 nrst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[20];
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int   sa, sb;
    logic a_zero;
    logic iv, ordy, fl, clr, e_ir_a, e_ov_a, e_ir_b, e_ov_b;
    logic [7:0] d;

    //          iv  d     ordy fl clr  ir ov ck od    st
    tbl[0]  = mk(1, 'h11, 1, 0, 0,   1, 0, 0, 'h00, 0);
    tbl[1]  = mk(1, 'h22, 1, 0, 0,   1, 1, 1, 'h11, 0);
    tbl[2]  = mk(1, 'h33, 1, 0, 0,   1, 1, 1, 'h22, 0);
    tbl[3]  = mk(0, 'h00, 1, 0, 0,   1, 1, 1, 'h33, 0);
    tbl[4]  = mk(1, 'h0A, 0, 0, 0,   1, 0, 0, 'h00, 0);
    tbl[5]  = mk(1, 'h0B, 0, 0, 0,   1, 1, 1, 'h0A, 0);
    tbl[6]  = mk(1, 'h0C, 0, 0, 0,   0, 1, 1, 'h0A, 1);
    tbl[7]  = mk(1, 'h0C, 0, 0, 0,   0, 1, 1, 'h0A, 2);
    tbl[8]  = mk(1, 'h0C, 1, 0, 0,   0, 1, 1, 'h0A, 3);
    tbl[9]  = mk(1, 'h0C, 1, 0, 0,   1, 1, 1, 'h0B, 3);
    tbl[10] = mk(0, 'h00, 1, 0, 0,   1, 1, 1, 'h0C, 3);
    tbl[11] = mk(0, 'h00, 1, 0, 0,   1, 0, 0, 'h00, 3);
    tbl[12] = mk(1, 'h05, 0, 0, 0,   1, 0, 0, 'h00, 3);
    tbl[13] = mk(1, 'h06, 0, 0, 0,   1, 1, 1, 'h05, 3);
    tbl[14] = mk(1, 'h07, 0, 0, 0,   0, 1, 1, 'h05, 4);
    tbl[15] = mk(1, 'h0D, 0, 1, 0,   0, 1, 1, 'h05, 5);
    tbl[16] = mk(1, 'h0E, 1, 1, 0,   1, 0, 1, 'h00, 6);
    tbl[17] = mk(0, 'h00, 1, 0, 0,   1, 0, 1, 'h00, 6);
    tbl[18] = mk(0, 'h00, 1, 0, 1,   1, 0, 1, 'h00, 6);
    tbl[19] = mk(0, 'h00, 1, 0, 0,   1, 0, 1, 'h00, 0);

    idle_all();
    do_reset();

    for (int i = 0; i < 20; i++) begin
      a_iv = tbl[i].iv; a_d = tbl[i].d; a_ordy = tbl[i].ordy; a_fl = tbl[i].fl; a_clr = tbl[i].clr;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), 32'(a_ir), 32'(tbl[i].ir));
      chk($sformatf("vec%0d_out_valid", i), 32'(a_ov), 32'(tbl[i].ov));
      if (tbl[i].ck) chk($sformatf("vec%0d_out_data", i), 32'(a_od), 32'(tbl[i].od));
      chk($sformatf("vec%0d_stall_cnt", i), 32'(a_st), 32'(tbl[i].st));
      @(posedge clk);
      #1;
    end

    // Asynchronous reset with main and skid both loaded
    a_fl = 0; a_clr = 0; a_ordy = 0; a_iv = 1; a_d = 8'h55;
    @(posedge clk); #1 a_d = 8'h66;
    @(posedge clk); #1 a_iv = 0;
    @(negedge clk);
    chk("pre_rst_in_ready", 32'(a_ir), 32'd0);
    #2 nrst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(a_ov), 32'd0);
    chk("rst_out_data", 32'(a_od), 32'd0);
    chk("rst_stall_cnt", 32'(a_st), 32'd0);
    @(posedge clk);
    #2 nrst = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(a_ir), 32'd1);
    chk("rel_out_valid", 32'(a_ov), 32'd0);
    chk("rel_out_data", 32'(a_od), 32'd0);
    @(posedge clk); #1;

    // Saturating counter on the 3-bit instance
    c_ordy = 0; c_iv = 1; c_d = 8'h3C;
    @(posedge clk); #1 c_iv = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("cnt_sat", 32'(c_st), 32'd7);
    chk("cnt_hold_valid", 32'(c_ov), 32'd1);
    @(negedge clk);
    chk("cnt_sat_hold", 32'(c_st), 32'd7);
    c_clr = 1;
    @(posedge clk); #1 c_clr = 0;
    @(negedge clk);
    chk("cnt_clr_wins", 32'(c_st), 32'd0);
    @(negedge clk);
    chk("cnt_after_clr", 32'(c_st), 32'd1);
    @(posedge clk); #1;

    // Random run of A and B against a FIFO-of-capacity reference
    idle_all();
    do_reset();
    sa = 0; sb = 0; a_zero = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      iv   = ($urandom_range(7) != 0);
      d    = 8'($urandom);
      ordy = $urandom_range(1) == 1;
      fl   = ($urandom_range(31) == 0);
      clr  = ($urandom_range(63) == 0);
      a_iv = iv; a_d = d; a_ordy = ordy; a_fl = fl; a_clr = clr;
      b_iv = iv; b_d = d; b_ordy = ordy; b_fl = fl; b_clr = clr;
      @(negedge clk);
      e_ir_a = (qa.size() < 2);
      e_ov_a = (qa.size() != 0);
      e_ir_b = (qb.size() == 0) || ordy;
      e_ov_b = (qb.size() != 0);
      chk("rnd_a_in_ready", 32'(a_ir), 32'(e_ir_a));
      chk("rnd_a_out_valid", 32'(a_ov), 32'(e_ov_a));
      if (e_ov_a) chk("rnd_a_out_data", 32'(a_od), 32'(qa[0]));
      else if (a_zero) chk("rnd_a_flushed_data", 32'(a_od), 32'd0);
      chk("rnd_a_stall_cnt", 32'(a_st), 32'(sa));
      chk("rnd_b_in_ready", 32'(b_ir), 32'(e_ir_b));
      chk("rnd_b_out_valid", 32'(b_ov), 32'(e_ov_b));
      if (e_ov_b) chk("rnd_b_out_data", 32'(b_od), 32'(qb[0]));
      chk("rnd_b_stall_cnt", 32'(b_st), 32'(sb));
      @(posedge clk);
      if (e_ov_a && ordy) void'(qa.pop_front());
      if (fl) begin
        qa.delete();
        a_zero = 1'b1;
      end else if (iv && e_ir_a) begin
        qa.push_back(d);
        a_zero = 1'b0;
      end
      if (e_ov_b && ordy) void'(qb.pop_front());
      if (fl) qb.delete();
      else if (iv && e_ir_b) qb.push_back(d);
      if (clr) sa = 0; else if (e_ov_a && !ordy && sa < 65535) sa++;
      if (clr) sb = 0; else if (e_ov_b && !ordy && sb < 65535) sb++;
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
